fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch stage feeding the decode/ALU stage that consumes the 3-bit op_mne opcode (ADD, AOL, CLR, BNE, LDR, STR, CMP, XOR).
- Owns the program counter, drives the instruction-ROM address, and registers each returned instruction into an IF/ID register with a valid bit.
- Resolves BNE redirects through a branch-target LUT, supports downstream stall, and signals program completion.

Parameters:
- PC_W, 10, program-counter / ROM address width
- INSTR_W, 9, instruction width; opcode is bits [INSTR_W-1 -: 3]
- LUT_IDX_W, 4, branch LUT index width; index is Instr_q[LUT_IDX_W-1:0]

Ports:
- Clk  in  1  single clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  pulse; begins a program run from IDLE or DONE
- ProgLen  in  PC_W  number of instructions in the program; sampled on Start
- Stall  in  1  downstream not ready; freeze PC and IF/ID register
- NeFlag  in  1  registered "not equal" flag from the last CMP, owned downstream
- PC  out  PC_W  instruction-ROM address
- Instr_in  in  INSTR_W  ROM read data for the current PC (combinational ROM)
- Instr_q  out  INSTR_W  registered instruction to decode
- Op  out  3  Instr_q opcode cast to op_mne
- Valid  out  1  Instr_q holds a real instruction
- Busy  out  1  state == RUN
- Done  out  1  state == DONE

Behaviour:
- Reset: state IDLE, PC=0, Instr_q=0, Valid=0, len register=0. Busy=0, Done=0. Reset wins over every other input, including mid-run.
- States:
  - IDLE: on Start, set PC=0, latch ProgLen, go to RUN. If ProgLen==0, go straight to DONE.
  - RUN: fetches as described below.
  - DONE: Valid=0; PC holds. On Start, restart exactly as from IDLE.
- Start while in RUN is ignored.
- Taken-branch condition: Valid & (Op==BNE) & NeFlag.
- RUN, Stall=1: PC, Instr_q, Valid and state all hold. A pending branch waits until Stall drops.
- RUN, Stall=0, branch taken:
  - PC <= LUT[Instr_q[LUT_IDX_W-1:0]].
  - Instr_q <= 0 and Valid <= 0 next cycle: the instruction fetched after BNE is flushed.
  - Penalty is exactly one bubble.
- RUN, Stall=0, no branch, PC < len: Instr_q <= Instr_in, Valid <= 1, PC <= PC+1.
- RUN, Stall=0, no branch, PC == len: Valid <= 0, go to DONE.
  - A BNE sitting in Instr_q at this point is still evaluated first, so a final-instruction loop-back works.
- Branch target >= len: PC loads it anyway; the next eligible cycle moves to DONE.
- Latency: the instruction at address A appears on Instr_q one cycle after PC==A, with no stall.
- Arithmetic: PC+1 is PC_W bits. Wrap cannot occur because len <= 2^PC_W-1.
- Op is a continuous cast of Instr_q's top 3 bits; it reads ADD when Instr_q is 0.

Decomposition:
- Shared package Definitions:
  - add the fetch-state enum (IDLE, RUN, DONE), 2 bits;
  - add the branch-LUT constants LUT_IDX_W and LUT_DEPTH=16;
  - op_mne is reused unchanged.
- Sub-module branch_lut:
  - combinational case table, LUT_IDX_W-bit index to PC_W-bit target;
  - default entry 0;
  - entries are program-specific constants.

Test Plan:
- Reset held 2 cycles, then Start with ProgLen=4 and ROM = ADD,XOR,CLR,STR, no stall.
  - PC steps 0,1,2,3,4.
  - Valid is high 4 consecutive cycles, with Op = ADD,XOR,CLR,STR.
  - Done rises the cycle after Op=STR and stays high.
- BNE at address 2 with index 5, LUT[5]=0, NeFlag=1.
  - After BNE on Instr_q: PC=0 next cycle, one cycle Valid=0, then addresses 0,1,2 re-fetched.
  - With NeFlag=0 instead: no bubble, falls through to address 3.
- Stall=1 for 3 cycles while Instr_q=CMP; separately, stall with BNE on Instr_q and NeFlag=1.
  - CMP case: PC, Instr_q, Valid frozen, then resume in order.
  - BNE case: redirect happens on the first cycle Stall=0.
- Last instruction is BNE taken back to 0, with ProgLen=3.
  - No DONE; loop repeats.
  - Drop NeFlag: DONE one cycle after the BNE retires.
- Reset asserted in RUN at PC=2.
  - Next cycle IDLE, PC=0, Valid=0.
  - Start with ProgLen=0 goes IDLE to DONE in one cycle with Valid never high.
- Start pulsed during RUN is ignored; Start pulsed in DONE restarts at PC=0 with the newly sampled ProgLen.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared opcode, fetch-state and branch-LUT definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      AOL = 3'd1,
      CLR = 3'd2,
      BNE = 3'd3,
      LDR = 3'd4,
      STR = 3'd5,
      CMP = 3'd6,
      XOR = 3'd7
   } op_mne;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

   localparam int LUT_IDX_W = 4;
   localparam int LUT_DEPTH = 16;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_branch_lut.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_branch_lut
// Description : Branch-target table, LUT index to program-counter target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer_branch_lut
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_W = 10
) (
   input  logic [LUT_IDX_W-1:0] idx,
   output logic [PC_W-1:0]      target
);

   // Entries are tied to the program image loaded in the instruction ROM.
   always_comb begin
      target = '0;
      case (idx)
         LUT_IDX_W'(5):  target = PC_W'(0);
         LUT_IDX_W'(6):  target = PC_W'(1);
         LUT_IDX_W'(7):  target = PC_W'(2);
         LUT_IDX_W'(8):  target = PC_W'(4);
         LUT_IDX_W'(10): target = PC_W'(12);
         default:        target = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch stage: PC, IF/ID register, BNE redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_W    = 10,
   parameter int INSTR_W = 9
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [PC_W-1:0]    ProgLen,
   input  logic               Stall,
   input  logic               NeFlag,
   output logic [PC_W-1:0]    PC,
   input  logic [INSTR_W-1:0] Instr_in,
   output logic [INSTR_W-1:0] Instr_q,
   output logic [2:0]         Op,
   output logic               Valid,
   output logic               Busy,
   output logic               Done
);

   fetch_state_t         r_state;
   logic [PC_W-1:0]      r_pc;
   logic [PC_W-1:0]      r_len;
   logic [INSTR_W-1:0]   r_instr;
   logic                 r_valid;
   logic [PC_W-1:0]      w_target;
   logic                 w_taken;

   fetch_sequencer_branch_lut #(
      .PC_W (PC_W)
   ) u_branch_lut (
      .idx    (r_instr[LUT_IDX_W-1:0]),
      .target (w_target)
   );

   assign w_taken = r_valid & (op_mne'(r_instr[INSTR_W-1 -: 3]) == BNE) & NeFlag;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_len   <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_valid <= 1'b0;
               if (Start) begin
                  r_pc    <= '0;
                  r_len   <= ProgLen;
                  r_state <= (ProgLen == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               // A pending BNE is resolved before the end-of-program test so
               // that a loop-back on the final instruction keeps running.
               if (!Stall) begin
                  if (w_taken) begin
                     r_pc    <= w_target;
                     r_instr <= '0;
                     r_valid <= 1'b0;
                  end else if (r_pc < r_len) begin
                     r_instr <= Instr_in;
                     r_valid <= 1'b1;
                     r_pc    <= r_pc + PC_W'(1);
                  end else begin
                     r_valid <= 1'b0;
                     r_state <= DONE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign PC      = r_pc;
   assign Instr_q = r_instr;
   assign Op      = r_instr[INSTR_W-1 -: 3];
   assign Valid   = r_valid;
   assign Busy    = (r_state == RUN);
   assign Done    = (r_state == DONE);

endmodule
`default_nettype wire
